// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - UART boot loader writing a little-endian word image into ram
module uart_loader #(
  parameter int          CLKS_PER_BIT = 104,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter logic [7:0]  MAGIC        = 8'hA5
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        rx,
  output logic        memwrite,
  output logic [31:0] addr,
  output logic [31:0] wd,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    L_WAIT_MAGIC,
    L_LEN_LO,
    L_LEN_HI,
    L_DATA,
    L_WRITE,
    L_DONE,
    L_ERROR
  } ld_state_t;

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------
  logic            rx_s1, rx_s2, rx_d;
  logic            rx_fall;
  rx_state_t       rx_state, rx_next;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      rx_shift;
  logic            rx_tick;
  logic            byte_valid;
  logic            frame_err;

  // Two-flop synchronizer plus one delay stage for start-edge detection; preset high (idle line)
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Start edge and sample instants: mid start bit after half a bit, then every full bit
  always_comb begin
    rx_fall = rx_d & ~rx_s2;
    rx_tick = 1'b0;
    case (rx_state)
      RX_START:         rx_tick = (cnt == HALF_M1);
      RX_DATA, RX_STOP: rx_tick = (cnt == FULL_M1);
      default:          rx_tick = 1'b0;
    endcase
  end

  // Receiver state register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) rx_state <= RX_IDLE;
    else          rx_state <= rx_next;
  end

  // Receiver next state; a high start-bit sample is a glitch and returns to idle
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && bit_cnt == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Receiver outputs: one-cycle byte or framing-error pulse at the stop-bit sample
  always_comb begin
    byte_valid = (rx_state == RX_STOP) && rx_tick && rx_s2;
    frame_err  = (rx_state == RX_STOP) && rx_tick && !rx_s2;
  end

  // Bit timing counter, bit index and LSB-first shift register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state == RX_IDLE || rx_tick) cnt <= '0;
      else                                cnt <= cnt + 1'b1;
      if (rx_state == RX_START && rx_tick) bit_cnt <= '0;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        bit_cnt  <= bit_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Loader
  // ---------------------------------------------------------------------------
  ld_state_t   ld_state, ld_next;
  logic [15:0] len;
  logic [15:0] k;
  logic [1:0]  bidx;
  logic [23:0] word;
  logic        in_frame;

  // Loader state register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) ld_state <= L_WAIT_MAGIC;
    else          ld_state <= ld_next;
  end

  // Loader next state; a framing error inside a frame is fatal until reset
  always_comb begin
    ld_next  = ld_state;
    in_frame = (ld_state != L_WAIT_MAGIC) && (ld_state != L_DONE) && (ld_state != L_ERROR);
    if (frame_err && in_frame) begin
      ld_next = L_ERROR;
    end else begin
      case (ld_state)
        L_WAIT_MAGIC: if (byte_valid && rx_shift == MAGIC) ld_next = L_LEN_LO;
        L_LEN_LO:     if (byte_valid) ld_next = L_LEN_HI;
        L_LEN_HI:     if (byte_valid) ld_next = ({rx_shift, len[7:0]} == 16'd0) ? L_DONE : L_DATA;
        L_DATA:       if (byte_valid && bidx == 2'd3) ld_next = L_WRITE;
        L_WRITE:      ld_next = (k == len - 16'd1) ? L_DONE : L_DATA;
        L_DONE:       ld_next = L_DONE;
        L_ERROR:      ld_next = L_ERROR;
        default:      ld_next = L_WAIT_MAGIC;
      endcase
    end
  end

  // Loader outputs decoded from state; the strobe lasts exactly the WRITE cycle
  always_comb begin
    memwrite  = (ld_state == L_WRITE);
    busy      = (ld_state == L_LEN_LO) || (ld_state == L_LEN_HI) ||
                (ld_state == L_DATA)   || (ld_state == L_WRITE);
    done      = (ld_state == L_DONE);
    err       = (ld_state == L_ERROR);
    cpu_reset = (ld_state != L_DONE);
  end

  // Length capture, byte packing, word index, and the held addr/wd write registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      len  <= '0;
      k    <= '0;
      bidx <= '0;
      word <= '0;
      addr <= BASE_ADDR;
      wd   <= '0;
    end else begin
      case (ld_state)
        L_LEN_LO: if (byte_valid) len[7:0] <= rx_shift;
        L_LEN_HI: begin
          if (byte_valid) begin
            len[15:8] <= rx_shift;
            k         <= '0;
            bidx      <= '0;
          end
        end
        L_DATA: begin
          if (byte_valid) begin
            case (bidx)
              2'd0: word[7:0]   <= rx_shift;
              2'd1: word[15:8]  <= rx_shift;
              2'd2: word[23:16] <= rx_shift;
              default: begin
                addr <= BASE_ADDR + {14'b0, k, 2'b00};
                wd   <= {rx_shift, word};
              end
            endcase
            bidx <= bidx + 2'd1;
          end
        end
        L_WRITE: k <= k + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - directed vector bench for uart_loader
module tb_uart_loader;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        rx = 1'b1;
  logic        memwrite;
  logic [31:0] addr, wd;
  logic        cpu_reset, busy, done, err;

  uart_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0), .MAGIC(8'hA5)) dut (
    .clk(clk), .n_reset(n_reset), .rx(rx), .memwrite(memwrite), .addr(addr),
    .wd(wd), .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] data;
    int           nbytes;
    int           bad_idx;
    int           exp_n;
    logic [31:0]  a0, w0, a1, w1;
    logic         exp_done, exp_err;
  } vec_t;

  vec_t vecs[6];

  int tests = 0;
  int fails = 0;

  logic [31:0] wa[$];
  logic [31:0] ww[$];
  int  cyc = 0;
  int  strobe_cyc = -1;
  int  fall_cyc = -1;
  bit  dbl = 0;
  logic prev_mw = 1'b0;
  logic prev_cr = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (memwrite) begin
      wa.push_back(addr);
      ww.push_back(wd);
      strobe_cyc = cyc;
      if (prev_mw) dbl = 1;
    end
    if (prev_cr && !cpu_reset) fall_cyc = cyc;
    prev_mw = memwrite;
    prev_cr = cpu_reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_reset = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    wa.delete();
    ww.delete();
    dbl = 0;
    fall_cyc = -1;
    strobe_cyc = -1;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " memwrite"}, {31'b0, memwrite}, 32'd0);
    chk({tag, " addr"}, addr, 32'h0);
    chk({tag, " wd"}, wd, 32'h0);
    chk({tag, " cpu_reset"}, {31'b0, cpu_reset}, 32'd1);
    chk({tag, " busy"}, {31'b0, busy}, 32'd0);
    chk({tag, " done"}, {31'b0, done}, 32'd0);
    chk({tag, " err"}, {31'b0, err}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{"t1_single", 128'hDEADBEEF0001A5, 7, -1, 1,
                32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[1] = '{"t2_two_words", 128'h08070605040302010002A55A00, 13, -1, 2,
                32'h0, 32'h04030201, 32'h4, 32'h08070605, 1'b1, 1'b0};
    vecs[2] = '{"t3_empty", 128'h0000A5, 3, -1, 0,
                32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[3] = '{"t4_frame_err", 128'h55443322110001A5, 8, 5, 0,
                32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[4] = '{"extremes", 128'hFFFFFFFF000000000002A5, 11, -1, 2,
                32'h0, 32'h00000000, 32'h4, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[5] = '{"magic_in_data", 128'h0001A5A50001A5, 7, -1, 1,
                32'h0, 32'h0001A5A5, 32'h0, 32'h0, 1'b1, 1'b0};

    // reset state while n_reset is held low
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].nbytes; i++) begin
        logic [127:0] d;
        d = vecs[v].data;
        send_byte(d[8*i +: 8], (i != vecs[v].bad_idx));
      end
      repeat (10) @(negedge clk);
      chk({vecs[v].name, " n_writes"}, 32'(wa.size()), 32'(vecs[v].exp_n));
      for (int j = 0; j < vecs[v].exp_n && j < wa.size(); j++) begin
        chk({vecs[v].name, " addr"}, wa[j], (j == 0) ? vecs[v].a0 : vecs[v].a1);
        chk({vecs[v].name, " wd"}, ww[j], (j == 0) ? vecs[v].w0 : vecs[v].w1);
      end
      chk({vecs[v].name, " done"}, {31'b0, done}, {31'b0, vecs[v].exp_done});
      chk({vecs[v].name, " err"}, {31'b0, err}, {31'b0, vecs[v].exp_err});
      chk({vecs[v].name, " cpu_reset"}, {31'b0, cpu_reset}, {31'b0, ~vecs[v].exp_done});
      chk({vecs[v].name, " busy"}, {31'b0, busy}, 32'd0);
      chk({vecs[v].name, " double_strobe"}, {31'b0, dbl}, 32'd0);
      if (vecs[v].exp_n > 0) begin
        chk({vecs[v].name, " addr_hold"}, addr, (vecs[v].exp_n == 1) ? vecs[v].a0 : vecs[v].a1);
        chk({vecs[v].name, " wd_hold"}, wd, (vecs[v].exp_n == 1) ? vecs[v].w0 : vecs[v].w1);
        if (vecs[v].exp_done)
          chk({vecs[v].name, " cpu_reset_lag"}, 32'(fall_cyc - strobe_cyc), 32'd1);
      end
    end

    // glitch shorter than half a bit while idle, then a normal frame
    do_reset();
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch busy", {31'b0, busy}, 32'd0);
    chk("glitch n_writes", 32'(wa.size()), 32'd0);
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (10) @(negedge clk);
    chk("glitch_after n_writes", 32'(wa.size()), 32'd1);
    if (wa.size() > 0) chk("glitch_after wd", ww[0], 32'h12345678);
    chk("glitch_after done", {31'b0, done}, 32'd1);

    // asynchronous reset mid-word aborts; only the resent frame is written
    do_reset();
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    chk("abort busy_before", {31'b0, busy}, 32'd1);
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    chk_reset_vals("abort");
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1); send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    repeat (10) @(negedge clk);
    chk("abort n_writes", 32'(wa.size()), 32'd1);
    if (wa.size() > 0) begin
      chk("abort addr", wa[0], 32'h0);
      chk("abort wd", ww[0], 32'hDDCCBBAA);
    end
    chk("abort done", {31'b0, done}, 32'd1);
    chk("abort cpu_reset", {31'b0, cpu_reset}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
